// File: rtl/PARAMS_BN254_d0.sv
// Shared BN254 Fp2 datapath types: redundant operand format, preadder modes, issue-beat record
// and the issue-stage state encoding.
package PARAMS_BN254_d0;

  localparam int unsigned POLY_LIMBS  = 3;
  localparam int unsigned POLY_LIMB_W = 90;
  localparam int unsigned POLY_W      = POLY_LIMBS * POLY_LIMB_W;

  typedef logic [POLY_LIMBS-1:0][POLY_LIMB_W-1:0] redundant_poly_L3;

  // Tag width carried by the beat record handed to the downstream accumulator.
  localparam int unsigned ISSUE_TAG_W = 4;

  typedef enum logic [1:0] {
    PASS    = 2'b00,
    SUMDIFF = 2'b01,
    KARA    = 2'b10
  } preadd_mode_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MUL0 = 3'd1,
    MUL1 = 3'd2,
    MUL2 = 3'd3,
    SQR0 = 3'd4,
    SQR1 = 3'd5
  } issue_state_t;

  typedef struct packed {
    redundant_poly_L3       X;
    redundant_poly_L3       Y;
    preadd_mode_t           mode;
    logic [1:0]             beat;
    logic                   last;
    logic                   sqr;
    logic [ISSUE_TAG_W-1:0] tag;
  } fp2_issue_beat_t;

  function automatic logic is_accept_state(issue_state_t s);
    return (s == IDLE) || (s == MUL2) || (s == SQR1);
  endfunction

endpackage

// File: rtl/mode_delay_line.sv
// Preadder-mode delay line: DEPTH-stage shift register with synchronous clear.
// DEPTH = 0 is a plain wire so the mode stays aligned with its beat.
module mode_delay_line
  import PARAMS_BN254_d0::*;
#(
  parameter int unsigned DEPTH = 1
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  preadd_mode_t i_mode,
  output preadd_mode_t o_mode
);

  if (DEPTH == 0) begin : g_bypass
    logic w_unused;
    assign w_unused = i_clk ^ i_clr;
    assign o_mode   = i_mode;
  end else begin : g_delay
    localparam int unsigned PIPE_W = 2 * DEPTH;

    logic [PIPE_W-1:0] r_pipe;

    // Newest mode enters at the bottom; the oldest falls off the top.
    always_ff @(posedge i_clk) begin
      if (i_clr) begin
        r_pipe <= '0;
      end else begin
        r_pipe <= PIPE_W'({r_pipe, i_mode});
      end
    end

    assign o_mode = preadd_mode_t'(r_pipe[PIPE_W-1 -: 2]);
  end

endmodule

// File: rtl/fp2_operand_issue.sv
// Fp2 operand issue stage: accepts one multiply/square request and streams the Karatsuba
// (3-beat) or complex-squaring (2-beat) operand pairs and preadder modes.
module fp2_operand_issue
  import PARAMS_BN254_d0::*;
#(
  parameter int unsigned TAG_W    = ISSUE_TAG_W,
  parameter int unsigned MODE_DLY = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic             i_in_sqr,
  input  redundant_poly_L3 i_in_a0,
  input  redundant_poly_L3 i_in_a1,
  input  redundant_poly_L3 i_in_b0,
  input  redundant_poly_L3 i_in_b1,
  input  logic [TAG_W-1:0] i_in_tag,
  input  logic             i_stall,
  output redundant_poly_L3 o_x,
  output redundant_poly_L3 o_y,
  output logic [1:0]       o_mode,
  output logic             o_out_valid,
  output logic [1:0]       o_out_beat,
  output logic             o_out_last,
  output logic             o_out_sqr,
  output logic [TAG_W-1:0] o_out_tag
);

  issue_state_t     r_state;
  redundant_poly_L3 r_a0, r_a1, r_b0, r_b1;
  logic             r_sqr;
  logic [TAG_W-1:0] r_tag;
  redundant_poly_L3 r_x, r_y;
  preadd_mode_t     r_mode;
  logic             r_valid;
  logic [1:0]       r_beat;
  logic             r_last;

  logic             w_ready;
  logic             w_accept;
  issue_state_t     w_state_d;
  redundant_poly_L3 w_a0, w_a1, w_b0, w_b1;
  logic             w_sqr;
  logic [TAG_W-1:0] w_tag;
  redundant_poly_L3 w_x_d, w_y_d;
  preadd_mode_t     w_mode_d;
  logic             w_valid_d;
  logic [1:0]       w_beat_d;
  logic             w_last_d;
  preadd_mode_t     w_mode_dly;

  // Ready never looks at i_in_valid, so upstream may wait on it without a loop.
  assign w_ready  = is_accept_state(r_state) && !i_stall && !i_rst;
  assign w_accept = w_ready && i_in_valid;

  // Operands seen by the next beat: fresh inputs on accept, stored copy otherwise.
  always_comb begin
    w_a0  = w_accept ? i_in_a0  : r_a0;
    w_a1  = w_accept ? i_in_a1  : r_a1;
    w_b0  = w_accept ? i_in_b0  : r_b0;
    w_b1  = w_accept ? i_in_b1  : r_b1;
    w_sqr = w_accept ? i_in_sqr : r_sqr;
    w_tag = w_accept ? i_in_tag : r_tag;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      IDLE, MUL2, SQR1: begin
        if (w_accept) begin
          w_state_d = i_in_sqr ? SQR0 : MUL0;
        end else begin
          w_state_d = IDLE;
        end
      end
      MUL0:    w_state_d = MUL1;
      MUL1:    w_state_d = MUL2;
      SQR0:    w_state_d = SQR1;
      default: w_state_d = IDLE;
    endcase
  end

  // Beat contents are decoded from the next state so every output is a register.
  always_comb begin
    w_x_d     = '0;
    w_y_d     = '0;
    w_mode_d  = PASS;
    w_valid_d = 1'b0;
    w_beat_d  = 2'd0;
    w_last_d  = 1'b0;
    unique case (w_state_d)
      MUL0: begin
        w_x_d     = w_a0;
        w_y_d     = w_b0;
        w_valid_d = 1'b1;
      end
      MUL1: begin
        w_x_d     = w_a1;
        w_y_d     = w_b1;
        w_valid_d = 1'b1;
        w_beat_d  = 2'd1;
      end
      MUL2: begin
        // Preadder adds the MUL1 beat, yielding (a0+a1, b0+b1).
        w_x_d     = w_a0;
        w_y_d     = w_b0;
        w_mode_d  = KARA;
        w_valid_d = 1'b1;
        w_beat_d  = 2'd2;
        w_last_d  = 1'b1;
      end
      SQR0: begin
        w_x_d     = w_a0;
        w_y_d     = w_a1;
        w_mode_d  = SUMDIFF;
        w_valid_d = 1'b1;
      end
      SQR1: begin
        w_x_d     = w_a0;
        w_y_d     = w_a1;
        w_valid_d = 1'b1;
        w_beat_d  = 2'd1;
        w_last_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_a0    <= '0;
      r_a1    <= '0;
      r_b0    <= '0;
      r_b1    <= '0;
      r_sqr   <= 1'b0;
      r_tag   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_mode  <= PASS;
      r_valid <= 1'b0;
      r_beat  <= 2'd0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_a0    <= w_a0;
      r_a1    <= w_a1;
      r_b0    <= w_b0;
      r_b1    <= w_b1;
      r_sqr   <= w_sqr;
      r_tag   <= w_tag;
      r_x     <= w_x_d;
      r_y     <= w_y_d;
      r_mode  <= w_mode_d;
      r_valid <= w_valid_d;
      r_beat  <= w_beat_d;
      r_last  <= w_last_d;
    end
  end

  mode_delay_line #(
    .DEPTH(MODE_DLY)
  ) u_mode_dly (
    .i_clk (i_clk),
    .i_clr (i_rst),
    .i_mode(r_mode),
    .o_mode(w_mode_dly)
  );

  assign o_in_ready  = w_ready;
  assign o_x         = r_x;
  assign o_y         = r_y;
  assign o_mode      = w_mode_dly;
  assign o_out_valid = r_valid;
  assign o_out_beat  = r_beat;
  assign o_out_last  = r_last;
  assign o_out_sqr   = r_sqr;
  assign o_out_tag   = r_tag;

endmodule

// File: tb/tb_fp2_operand_issue.sv
// Bench for fp2_operand_issue: a scoreboard of expected beats drives three builds
// (MODE_DLY = 0, 1, 3) in lockstep and checks every output each cycle.
module tb_fp2_operand_issue;
  import PARAMS_BN254_d0::*;

  localparam int unsigned TW = ISSUE_TAG_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_sqr;
  logic             stall;
  redundant_poly_L3 a0, a1, b0, b1;
  logic [TW-1:0]    tag;

  // Index 0: MODE_DLY=0, 1: MODE_DLY=1, 2: MODE_DLY=3.
  logic             ordy  [3];
  redundant_poly_L3 ox    [3];
  redundant_poly_L3 oy    [3];
  logic [1:0]       omode [3];
  logic             ovld  [3];
  logic [1:0]       obeat [3];
  logic             olast [3];
  logic             osqr  [3];
  logic [TW-1:0]    otag  [3];

  fp2_operand_issue #(.TAG_W(TW), .MODE_DLY(0)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(ordy[0]), .i_in_sqr(in_sqr),
    .i_in_a0(a0), .i_in_a1(a1), .i_in_b0(b0), .i_in_b1(b1), .i_in_tag(tag), .i_stall(stall),
    .o_x(ox[0]), .o_y(oy[0]), .o_mode(omode[0]), .o_out_valid(ovld[0]), .o_out_beat(obeat[0]),
    .o_out_last(olast[0]), .o_out_sqr(osqr[0]), .o_out_tag(otag[0])
  );

  fp2_operand_issue #(.TAG_W(TW), .MODE_DLY(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(ordy[1]), .i_in_sqr(in_sqr),
    .i_in_a0(a0), .i_in_a1(a1), .i_in_b0(b0), .i_in_b1(b1), .i_in_tag(tag), .i_stall(stall),
    .o_x(ox[1]), .o_y(oy[1]), .o_mode(omode[1]), .o_out_valid(ovld[1]), .o_out_beat(obeat[1]),
    .o_out_last(olast[1]), .o_out_sqr(osqr[1]), .o_out_tag(otag[1])
  );

  fp2_operand_issue #(.TAG_W(TW), .MODE_DLY(3)) u_dut3 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(ordy[2]), .i_in_sqr(in_sqr),
    .i_in_a0(a0), .i_in_a1(a1), .i_in_b0(b0), .i_in_b1(b1), .i_in_tag(tag), .i_stall(stall),
    .o_x(ox[2]), .o_y(oy[2]), .o_mode(omode[2]), .o_out_valid(ovld[2]), .o_out_beat(obeat[2]),
    .o_out_last(olast[2]), .o_out_sqr(osqr[2]), .o_out_tag(otag[2])
  );

  always #5 clk = ~clk;

  fp2_issue_beat_t sb_q [$];
  int              m_cnt;     // beats still to appear, counting the current cycle's
  preadd_mode_t    hist [4];  // hist[i]: expected mode source i cycles ago
  int              n_chk;
  int              n_err;
  int              run;
  logic            done = 1'b0;

  task automatic chk(input string nm, input logic [POLY_W-1:0] obs,
                     input logic [POLY_W-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", nm, obs, exp);
    end
  endtask

  initial begin
    repeat (2000) @(posedge clk);
    if (!done) begin
      $error("FAIL timeout: stimulus did not complete within 2000 cycles");
      $fatal(1);
    end
  end

  function automatic redundant_poly_L3 poly(input int unsigned v);
    return POLY_W'(v);
  endfunction

  function automatic redundant_poly_L3 rnd_poly();
    redundant_poly_L3 p;
    for (int i = 0; i < int'(POLY_W); i++) p[i] = 1'($urandom_range(0, 1));
    return p;
  endfunction

  function automatic fp2_issue_beat_t mk(input redundant_poly_L3 x, input redundant_poly_L3 y,
                                         input preadd_mode_t m, input logic [1:0] bt,
                                         input logic lst);
    fp2_issue_beat_t e;
    e.X    = x;
    e.Y    = y;
    e.mode = m;
    e.beat = bt;
    e.last = lst;
    e.sqr  = in_sqr;
    e.tag  = tag;
    return e;
  endfunction

  task automatic push_req();
    if (in_sqr) begin
      sb_q.push_back(mk(a0, a1, SUMDIFF, 2'd0, 1'b0));
      sb_q.push_back(mk(a0, a1, PASS,    2'd1, 1'b1));
      m_cnt = 2;
    end else begin
      sb_q.push_back(mk(a0, b0, PASS, 2'd0, 1'b0));
      sb_q.push_back(mk(a1, b1, PASS, 2'd1, 1'b0));
      sb_q.push_back(mk(a0, b0, KARA, 2'd2, 1'b1));
      m_cnt = 3;
    end
  endtask

  task automatic check_cycle();
    fp2_issue_beat_t e;
    preadd_mode_t    src;
    logic            exp_rdy;
    exp_rdy = (m_cnt <= 1) && !stall && !rst;
    src     = PASS;
    if (ovld[1]) run++;
    if (m_cnt > 0) begin
      e   = sb_q.pop_front();
      src = e.mode;
    end
    for (int i = 0; i < 3; i++) begin
      chk("in_ready", ordy[i], exp_rdy);
      if (m_cnt > 0) begin
        chk("out_valid", ovld[i], 1'b1);
        chk("x", ox[i], e.X);
        chk("y", oy[i], e.Y);
        chk("out_beat", obeat[i], e.beat);
        chk("out_last", olast[i], e.last);
        chk("out_sqr", osqr[i], e.sqr);
        chk("out_tag", otag[i], e.tag);
      end else begin
        chk("idle_valid", ovld[i], 1'b0);
        chk("idle_x", ox[i], poly(0));
        chk("idle_y", oy[i], poly(0));
        chk("idle_beat", obeat[i], 2'd0);
        chk("idle_last", olast[i], 1'b0);
      end
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = src;
    chk("mode_dly0", omode[0], hist[0]);
    chk("mode_dly1", omode[1], hist[1]);
    chk("mode_dly3", omode[2], hist[3]);
  endtask

  task automatic update_model();
    if (rst) begin
      sb_q.delete();
      m_cnt = 0;
      for (int i = 0; i < 4; i++) hist[i] = PASS;
    end else if (in_valid && !stall && (m_cnt <= 1)) begin
      push_req();
    end else if (m_cnt > 0) begin
      m_cnt--;
    end
  endtask

  task automatic tick();
    #1;
    check_cycle();
    @(posedge clk);
    update_model();
    #1;
  endtask

  task automatic set_req(input logic sq, input int unsigned va0, input int unsigned va1,
                         input int unsigned vb0, input int unsigned vb1, input int unsigned vt);
    in_sqr = sq;
    a0     = poly(va0);
    a1     = poly(va1);
    b0     = poly(vb0);
    b1     = poly(vb1);
    tag    = TW'(vt);
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    run      = 0;
    m_cnt    = 0;
    for (int i = 0; i < 4; i++) hist[i] = PASS;
    rst      = 1'b1;
    in_valid = 1'b0;
    stall    = 1'b0;
    set_req(1'b0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    tick();  // reset state, rst still high
    rst = 1'b0;
    tick();

    // Multiply 1,2 x 3,4
    set_req(1'b0, 1, 2, 3, 4, 5);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();

    // Square 5,7; b inputs carry junk
    set_req(1'b1, 5, 7, 9, 11, 6);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();

    // Multiply then square with valid held high
    set_req(1'b0, 10, 20, 30, 40, 1);
    in_valid = 1'b1;
    tick();
    set_req(1'b1, 50, 60, 0, 0, 2);
    run = 0;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (2) tick();
    chk("b2b_valid_run", run, 5);
    repeat (4) tick();

    // Stall raised during MUL1 with a request pending
    set_req(1'b0, 1, 2, 3, 4, 7);
    in_valid = 1'b1;
    tick();
    set_req(1'b1, 8, 9, 0, 0, 8);
    tick();
    stall = 1'b1;
    repeat (3) tick();
    stall = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();

    // Reset during MUL1, then a clean restart
    set_req(1'b0, 1, 2, 3, 4, 3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    set_req(1'b0, 11, 12, 13, 14, 4);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();

    // Random traffic with stalls and occasional resets
    for (int n = 0; n < 80; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      stall    = ($urandom_range(0, 4) == 0);
      rst      = ($urandom_range(0, 29) == 0);
      in_sqr   = 1'($urandom_range(0, 1));
      a0       = rnd_poly();
      a1       = rnd_poly();
      b0       = rnd_poly();
      b1       = rnd_poly();
      tag      = TW'($urandom_range(0, 15));
      tick();
    end
    rst      = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    repeat (6) tick();

    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
